// File: rtl/ifu.sv
// Instruction fetch unit: in-order bus fetcher with a small instruction buffer and jump redirect.
// Optional misaligned-redirect fault handling is enabled by defining IFU_MISALIGN_CHECK_EN.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef IFU_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {FETCH, DRAIN, FAULT} state_t;
`else
    typedef enum logic {FETCH, DRAIN} state_t;
`endif

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;

    logic [31:0]     aq_addr [DEPTH];
    logic [AW-1:0]   aq_rd, aq_wr;

    logic [31:0]     buf_pc   [DEPTH];
    logic [31:0]     buf_inst [DEPTH];
    logic [AW-1:0]   bq_rd, bq_wr;
    logic [CW-1:0]   bq_cnt;

    logic            can_fetch;
    logic [CW:0]     inflight;
    logic            grant, resp, drop, keep, pop, misaligned;
    logic [CW-1:0]   out_next;
    logic [31:0]     jump_target;

`ifdef IFU_MISALIGN_CHECK_EN
    assign can_fetch   = (state != FAULT);
    assign misaligned  = (jump_addr[1:0] != 2'b00);
    assign fetch_fault = !rst && (state == FAULT);
`else
    logic jump_lsb_unused;
    assign jump_lsb_unused = ^jump_addr[1:0];
    assign can_fetch   = 1'b1;
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Buffered plus in-flight fetches may never exceed the buffer size, so a response always has room.
    assign inflight    = {1'b0, bq_cnt} + {1'b0, outstanding};
    assign bus_req     = !rst && can_fetch && !jump_en && (inflight < (CW+1)'(DEPTH));
    assign bus_addr    = rst ? RESET_PC : fetch_pc;
    assign grant       = bus_req && bus_gnt;
    assign resp        = bus_rvalid && !rst;
    assign drop        = resp && (drop_cnt != '0);
    assign keep        = resp && (drop_cnt == '0);
    assign out_next    = outstanding + CW'(grant) - CW'(resp);
    assign pop         = (bq_cnt != '0) && !stall;
    assign jump_target = {jump_addr[31:2], 2'b00};

    assign inst_valid  = !rst && (bq_cnt != '0);
    assign pc_o        = inst_valid ? buf_pc[bq_rd]   : 32'h0;
    assign inst_o      = inst_valid ? buf_inst[bq_rd] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            bq_rd       <= '0;
            bq_wr       <= '0;
            bq_cnt      <= '0;
        end else begin
            outstanding <= out_next;
            if (jump_en) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= jump_target;
                drop_cnt <= out_next;
                aq_rd    <= '0;
                aq_wr    <= '0;
                bq_rd    <= '0;
                bq_wr    <= '0;
                bq_cnt   <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
                if (misaligned)
                    state <= FAULT;
                else
`endif
                    state <= (out_next != '0) ? DRAIN : FETCH;
            end else begin
                if (grant) begin
                    aq_addr[aq_wr] <= fetch_pc;
                    aq_wr          <= aq_wr + 1'b1;
                    fetch_pc       <= fetch_pc + 32'd4;
                end
                if (keep) begin
                    aq_rd           <= aq_rd + 1'b1;
                    buf_pc[bq_wr]   <= aq_addr[aq_rd];
                    buf_inst[bq_wr] <= bus_rdata;
                    bq_wr           <= bq_wr + 1'b1;
                end
                if (pop)
                    bq_rd <= bq_rd + 1'b1;
                bq_cnt <= bq_cnt + CW'(keep) - CW'(pop);
                if (drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                    if (state == DRAIN && drop_cnt == CW'(1))
                        state <= FETCH;
                end
            end
        end
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries, power of two, 2..8; also the limit on outstanding plus buffered fetches.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 bus_req  out  1  fetch request valid.
REQ-006 bus_addr  out  32  fetch address, word-aligned.
REQ-007 bus_gnt  in  1  request accepted this cycle.
REQ-008 bus_rvalid  in  1  read data valid; in order; at least 1 cycle after its grant.
REQ-009 bus_rdata  in  32  fetched instruction word.
REQ-010 jump_en  in  1  redirect request from execute.
REQ-011 jump_addr  in  32  redirect target.
REQ-012 stall  in  1  decode cannot accept the head instruction.
REQ-013 inst_valid  out  1  pc_o/inst_o hold a valid instruction.
REQ-014 pc_o  out  32  address of the head instruction.
REQ-015 inst_o  out  32  head instruction word.
REQ-016 fetch_fault  out  1  misaligned redirect fault; only with IFU_MISALIGN_CHECK_EN.

Function
REQ-017 Registered fetch_pc drives bus_addr; bus_req=1 when state is FETCH or DRAIN and (buffer count + outstanding) < DEPTH and jump_en=0.
REQ-018 On bus_req&&bus_gnt: fetch_pc += 4 (32-bit wrap, FFFF_FFFC -> 0000_0000); the issued address is queued in an address FIFO; outstanding += 1.
REQ-019 On bus_rvalid with drop_cnt=0: push {queued addr, bus_rdata} into the buffer; outstanding -= 1; the entry is visible at the output the following cycle, with no bypass.
REQ-020 On bus_rvalid with drop_cnt>0: discard the data; drop_cnt -= 1; outstanding -= 1.
REQ-021 inst_valid = buffer non-empty; pc_o/inst_o = head entry; when empty, pc_o=0 and inst_o=0.
REQ-022 Pop the head when inst_valid && !stall; a simultaneous push and pop leaves the count unchanged; a push when full cannot occur by REQ-017.
REQ-023 jump_en (highest priority) in cycle N:
- flush the buffer and address FIFO;
- fetch_pc <= jump_addr;
- drop_cnt <= outstanding after this cycle's grant/response events;
- inst_valid=0 from N+1.
REQ-024 Minimum latency: grant at cycle N -> rvalid at N+1 -> inst_valid at N+2; first bus_req is in the first cycle after rst deasserts.
REQ-025 FSM states FETCH, DRAIN, FAULT:
- FETCH -> DRAIN: jump with nonzero resulting drop_cnt.
- DRAIN -> FETCH: drop_cnt reaches 0.
- DRAIN accepts a further jump, reloading drop_cnt.
- Requests continue in DRAIN; their responses are kept, because the bus returns responses in order.
REQ-026 Outstanding and drop counters are clog2(DEPTH)+1 bits wide and never exceed DEPTH.

Reset
REQ-027 While rst=1:
- bus_req=0, bus_addr=RESET_PC;
- inst_valid=0, pc_o=0, inst_o=0, fetch_fault=0;
- buffers empty, counters 0, state FETCH.
REQ-028 Reset mid-operation discards all buffered and outstanding fetches; bus_rvalid is ignored while rst=1, and the bus slave shares rst, so no stale responses arrive afterwards.

Configuration
REQ-029 Macro IFU_MISALIGN_CHECK_EN defined: a jump with jump_addr[1:0]!=0 enters FAULT.
- In FAULT: bus_req=0, buffer flushed, fetch_fault=1, and pending responses are still dropped.
- Exit from FAULT only on a jump with an aligned target, entering FETCH or DRAIN per REQ-025.
REQ-030 Macro undefined: jump_addr[1:0] is ignored (forced to 2'b00); fetch_fault is tied 0; the FAULT state is absent.

Verification
REQ-031 RESET_PC=0x100, bus grants every cycle, rvalid 1 cycle later -> inst_valid first at cycle 3 after reset, pc_o 0x100, 0x104, 0x108 on consecutive cycles.
REQ-032 stall held 5 cycles with DEPTH=2 -> at most 2 grants issued, bus_req=0 afterwards, head pc_o unchanged; on release, in-order delivery with no loss or duplication.
REQ-033 jump_en to 0x200 with 2 fetches outstanding -> the 2 responses are dropped, the next inst_valid shows pc_o=0x200, and DRAIN is exited after the second drop.
REQ-034 fetch_pc=0xFFFF_FFFC -> next bus_addr=0x0000_0000.
REQ-035 Macro defined, jump to 0x202 -> fetch_fault=1 and bus_req=0 until a jump to 0x300, then the next inst_valid shows pc_o=0x300; macro undefined -> same stimulus fetches from 0x200.
REQ-036 rst pulsed for 1 cycle while 2 instructions are buffered -> inst_valid=0 next cycle, then the fetch restarts at RESET_PC.
